// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// FSM states, RV32I load/store funct3 encodings and mcause values.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [4:0] LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] LOAD_FAULT       = 5'd5;
  localparam logic [4:0] STORE_MISALIGNED = 5'd6;
  localparam logic [4:0] STORE_FAULT      = 5'd7;

  // funct3[1:0]: 00 byte, 01 half, anything else is treated as a word
  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load formatter: lane select plus sign/zero extension.
// Kept standalone so a cache read path can share it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  always_comb begin
    lane_b = 8'h00;
    case (off)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    sext   = ~funct3[2];
    case (funct3[1:0])
      2'b00:   data = {{24{sext & lane_b[7]}}, lane_b};
      2'b01:   data = {{16{sext & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per op, stalls until
// the response, then presents formatted data/exception for one cycle.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_wstrb_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        stall_o,
  output logic [31:0] mem_data_o,
  output logic [5:0]  exception_o
);

  state_t      state, next;
  logic        mem_op, aligned, issue, misal;
  logic [3:0]  strb;
  logic [31:0] lanes;
  logic [31:0] addr_q, wdata_q, fmt, res_data;
  logic [3:0]  strb_q;
  logic [2:0]  f3_q;
  logic        we_q, kill;
  logic [5:0]  res_exc;

  assign mem_op  = op_valid_i & (mem_rd_i | mem_wr_i) & ~flush_i;
  assign aligned = is_aligned(funct3_i, addr_i[1:0]);
  assign issue   = (state == IDLE) & mem_op & aligned & rst_n;
  assign misal   = (state == IDLE) & mem_op & ~aligned;

  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr_i[1:0];
        lanes = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr_i[1:0];
        lanes = {2{wdata_i[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        lanes = wdata_i;
      end
    endcase
  end

  load_align u_align (
    .rdata  (dmem_rdata_i),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (fmt)
  );

  always_comb begin
    next         = state;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_wstrb_o = 4'h0;
    dmem_wdata_o = 32'h0;
    stall_o      = 1'b0;
    mem_data_o   = 32'h0;
    exception_o  = 6'h0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (issue) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = mem_wr_i;
            dmem_addr_o  = {addr_i[31:2], 2'b00};
            dmem_wstrb_o = mem_wr_i ? strb : 4'h0;
            dmem_wdata_o = mem_wr_i ? lanes : 32'h0;
            stall_o      = 1'b1;
            next         = dmem_gnt_i ? WAIT_RSP : REQ;
          end else if (misal) begin
            exception_o = {1'b1, mem_rd_i ? LOAD_MISALIGNED
                                          : STORE_MISALIGNED};
          end
        end
        REQ: begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = we_q;
          dmem_addr_o  = {addr_q[31:2], 2'b00};
          dmem_wstrb_o = strb_q;
          dmem_wdata_o = wdata_q;
          stall_o      = 1'b1;
          if (dmem_gnt_i) next = WAIT_RSP;
        end
        WAIT_RSP: begin
          stall_o = 1'b1;
          if (dmem_rvalid_i) next = DONE;
        end
        DONE: begin
          next        = IDLE;
          mem_data_o  = kill ? 32'h0 : res_data;
          exception_o = kill ? 6'h0 : res_exc;
        end
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      kill     <= 1'b0;
      res_data <= 32'h0;
      res_exc  <= 6'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      strb_q   <= 4'h0;
      f3_q     <= 3'h0;
      we_q     <= 1'b0;
    end else begin
      state <= next;
      if (issue) begin
        addr_q  <= addr_i;
        wdata_q <= mem_wr_i ? lanes : 32'h0;
        strb_q  <= mem_wr_i ? strb : 4'h0;
        f3_q    <= funct3_i;
        we_q    <= mem_wr_i;
      end
      if (next == IDLE)
        kill <= 1'b0;
      else if (flush_i && (state == REQ || state == WAIT_RSP))
        kill <= 1'b1;
      // Stores return no data; a bus error zeroes the data either way
      if (state == WAIT_RSP && dmem_rvalid_i) begin
        if (dmem_err_i) begin
          res_data <= 32'h0;
          res_exc  <= {1'b1, we_q ? STORE_FAULT : LOAD_FAULT};
        end else begin
          res_data <= we_q ? 32'h0 : fmt;
          res_exc  <= 6'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single ops
// plus hand sequences for grant wait, flush and reset mid-transaction.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, mem_rd, mem_wr, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] mem_data;
  logic [5:0]  exception;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op_valid_i    (op_valid),
    .mem_rd_i      (mem_rd),
    .mem_wr_i      (mem_wr),
    .funct3_i      (funct3),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .flush_i       (flush),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_wstrb_o  (dmem_wstrb),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_gnt_i    (dmem_gnt),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata),
    .dmem_err_i    (dmem_err),
    .stall_o       (stall),
    .mem_data_o    (mem_data),
    .exception_o   (exception)
  );

  typedef struct {
    logic        misal;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic [5:0]  e_exc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    #3;
  endtask

  task automatic quiet;
    op_valid    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    flush       = 1'b0;
    funct3      = 3'b000;
    addr        = 32'h0;
    wdata       = 32'h0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    dmem_err    = 1'b0;
  endtask

  task automatic present(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    op_valid = 1'b1;
    mem_rd   = rd;
    mem_wr   = wr;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    step();
    present(v.rd, v.wr, v.f3, v.addr, v.wdata);
    dmem_gnt = 1'b1;
    sample();
    if (v.misal) begin
      check($sformatf("v%0d req", i), dmem_req, 0);
      check($sformatf("v%0d stall", i), stall, 0);
      check($sformatf("v%0d exc", i), exception, v.e_exc);
      step();
      quiet();
      return;
    end
    check($sformatf("v%0d req", i), dmem_req, 1);
    check($sformatf("v%0d stall0", i), stall, 1);
    check($sformatf("v%0d daddr", i), dmem_addr, v.e_addr);
    check($sformatf("v%0d we", i), dmem_we, v.wr);
    check($sformatf("v%0d strb", i), dmem_wstrb, v.e_strb);
    if (v.wr) check($sformatf("v%0d wdata", i), dmem_wdata, v.e_wdata);
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = v.rdata;
    dmem_err    = v.err;
    sample();
    check($sformatf("v%0d stall1", i), stall, 1);
    check($sformatf("v%0d req1", i), dmem_req, 0);
    step();
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
    sample();
    check($sformatf("v%0d done_stall", i), stall, 0);
    check($sformatf("v%0d done_req", i), dmem_req, 0);
    check($sformatf("v%0d data", i), mem_data, v.e_data);
    check($sformatf("v%0d done_exc", i), exception, v.e_exc);
    step();
    quiet();
    sample();
    check($sformatf("v%0d idle_stall", i), stall, 0);
  endtask

  initial begin
    // misal rd wr f3 addr wdata rdata err e_addr e_strb e_wdata e_data e_exc
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,
                 32'h80FF_1234, 1'b0, 32'h0000_1000, 4'h0, 32'h0,
                 32'hFFFF_FF80, 6'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD,
                 32'h0, 1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD,
                 32'h0, 6'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0,
                 32'hFFFF_0000, 1'b0, 32'h0000_3000, 4'h0, 32'h0,
                 32'h0000_FFFF, 6'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0,
                 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 6'b100100};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678,
                 32'h0, 1'b1, 32'h0000_5000, 4'b1111, 32'h1234_5678,
                 32'h0, 6'b100111};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0,
                 32'hCAFE_F00D, 1'b1, 32'h0000_6000, 4'h0, 32'h0,
                 32'h0, 6'b100101};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_7001, 32'h0000_00A5,
                 32'h0, 1'b0, 32'h0000_7000, 4'b0010, 32'hA5A5_A5A5,
                 32'h0, 6'h00};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_8001, 32'h0,
                 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 6'b100110};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_9002, 32'h0,
                 32'h8001_7FFF, 1'b0, 32'h0000_9000, 4'h0, 32'h0,
                 32'hFFFF_8001, 6'h00};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'b100, 32'h0000_A001, 32'h0,
                 32'h1234_F678, 1'b0, 32'h0000_A000, 4'h0, 32'h0,
                 32'h0000_00F6, 6'h00};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_B004, 32'h0,
                 32'hDEAD_BEEF, 1'b0, 32'h0000_B004, 4'h0, 32'h0,
                 32'hDEAD_BEEF, 6'h00};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_C000, 32'h0,
                 32'h0000_007F, 1'b0, 32'h0000_C000, 4'h0, 32'h0,
                 32'h0000_007F, 6'h00};

    quiet();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    sample();
    check("rst stall", stall, 0);
    check("rst req", dmem_req, 0);
    check("rst data", mem_data, 0);
    check("rst exc", exception, 0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // LW with grant held low for three cycles
    step();
    present(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0);
    for (int c = 0; c < 4; c++) begin
      dmem_gnt = (c == 3);
      sample();
      check($sformatf("gw%0d req", c), dmem_req, 1);
      check($sformatf("gw%0d addr", c), dmem_addr, 32'h0000_3000);
      check($sformatf("gw%0d stall", c), stall, 1);
      step();
      addr = 32'hFFFF_FFFC;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    sample();
    check("gw4 stall", stall, 1);
    step();
    dmem_rvalid = 1'b0;
    sample();
    check("gw done stall", stall, 0);
    check("gw done data", mem_data, 32'h1234_5678);
    step();
    quiet();

    // flush while waiting for the response
    step();
    present(1'b1, 1'b0, 3'b010, 32'h0000_D000, 32'h0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    flush    = 1'b1;
    sample();
    check("fl wait stall", stall, 1);
    step();
    flush       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_0055;
    step();
    dmem_rvalid = 1'b0;
    sample();
    check("fl done stall", stall, 0);
    check("fl done data", mem_data, 0);
    check("fl done exc", exception, 0);
    step();
    present(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    dmem_gnt = 1'b1;
    sample();
    check("fl next req", dmem_req, 1);
    check("fl next stall", stall, 1);
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_1234;
    step();
    dmem_rvalid = 1'b0;
    sample();
    check("fl next data", mem_data, 32'hFFFF_FF80);
    step();
    quiet();

    // reset in WAIT_RSP, then a stale response
    step();
    present(1'b1, 1'b0, 3'b010, 32'h0000_E000, 32'h0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n       = 1'b1;
    op_valid    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_0011;
    sample();
    check("rs stall", stall, 0);
    check("rs req", dmem_req, 0);
    check("rs data", mem_data, 0);
    check("rs exc", exception, 0);
    step();
    dmem_rvalid = 1'b0;
    sample();
    check("rs after stall", stall, 0);
    check("rs after data", mem_data, 0);
    check("rs after exc", exception, 0);
    step();
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the WB pipeline register. It issues one data-memory transaction per load/store over a request/grant/response bus. It stalls the pipeline until the response arrives, then formats load data (byte/half extraction, sign/zero extension). The aligned result and a 6-bit exception field feed the WB register's `mem_data_i` and `exception_i`.

## Interface
- No parameters; widths fixed at RV32 (32-bit address/data, 6-bit exception field).
- `clk` in 1: single clock. Reset is synchronous and active-low.
- `rst_n` in 1: synchronous, active-low reset.
- `op_valid_i` in 1: EX/MEM holds a valid instruction.
- `mem_rd_i` in 1: instruction is a load.
- `mem_wr_i` in 1: instruction is a store. Never asserted together with `mem_rd_i`.
- `funct3_i` in 3: size/sign, as RV32I load/store funct3.
- `addr_i` in 32: effective byte address.
- `wdata_i` in 32: store data, LSB-justified.
- `flush_i` in 1: kill the current MEM-stage instruction.
- `dmem_req_o` out 1: bus request.
- `dmem_we_o` out 1: 1 = write.
- `dmem_addr_o` out 32: word address, with `[1:0]` = 0.
- `dmem_wstrb_o` out 4: byte enables for writes; 0 for reads.
- `dmem_wdata_o` out 32: store data replicated into lanes.
- `dmem_gnt_i` in 1: request accepted this cycle.
- `dmem_rvalid_i` in 1: response valid.
- `dmem_rdata_i` in 32: read word.
- `dmem_err_i` in 1: bus error, qualified by `dmem_rvalid_i`.
- `stall_o` out 1: hold IF..MEM stages and the WB register enable low.
- `mem_data_o` out 32: formatted load result; 0 for stores and faults.
- `exception_o` out 6: bit 5 = exception valid, `[4:0]` = mcause.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE → WAIT_RSP on an issued request with `dmem_gnt_i`=1.
  - IDLE → REQ on an issued request with `dmem_gnt_i`=0.
  - REQ → WAIT_RSP on `dmem_gnt_i`.
  - WAIT_RSP → DONE on `dmem_rvalid_i`.
  - DONE → IDLE unconditionally.
- IDLE request: a mem op is `op_valid_i & (mem_rd_i|mem_wr_i) & ~flush_i`.
  - If aligned, `dmem_req_o` is driven combinationally from the inputs.
  - Address, we, strobes and wdata are registered for REQ so the request stays stable until granted. A request is never withdrawn.
- Alignment rules:
  - Byte access: always aligned.
  - Half access: needs `addr[0]`=0.
  - Word access (010 and any other funct3): needs `addr[1:0]`=0.
- Misaligned access in IDLE: no request, `stall_o`=0. `exception_o` = {1, 4} for a load or {1, 6} for a store, combinational, same cycle.
- Store strobes:
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `4'b0011 << addr[1:0]`.
  - SW: `4'b1111`.
  - Data lanes: byte replicated ×4, half replicated ×2.
- Load formatting uses the registered low address bits:
  - LB/LBU: select byte `addr[1:0]`, then sign/zero extend.
  - LH/LHU: select half `addr[1]`, then sign/zero extend.
  - LW: full word.
- Response capture: on `dmem_rvalid_i` the formatted data is captured into a result register.
  - With `dmem_err_i`=1, the captured exception is {1, 5} for a load or {1, 7} for a store, and the data is 0.
- DONE:
  - `stall_o`=0.
  - `mem_data_o`/`exception_o` come from the result register and are held for exactly that cycle.
  - No request is issued, even though EX/MEM still presents the same instruction.
- Flush:
  - In IDLE, flush suppresses the request and any exception.
  - In REQ/WAIT_RSP, flush sets a kill flag; the transaction still completes. In DONE, `exception_o`=0 and `mem_data_o`=0.
  - The kill flag clears on entry to IDLE.
- Non-memory or invalid op in IDLE: `stall_o`=0, `mem_data_o`=0, `exception_o`=0.

## Timing
- Reset, taken on the clock edge with `rst_n`=0, in any state:
  - State returns to IDLE; result register and kill flag cleared.
  - All outputs 0.
  - An in-flight bus response arriving after reset is ignored.
- `stall_o` = (IDLE & aligned mem op) | REQ | WAIT_RSP.
- Minimum latency, with op presented at cycle 0, grant at cycle 0 and `rvalid` at cycle 1:
  - Stall in cycles 0–1.
  - DONE in cycle 2, where the WB register captures the result.
- Each grant-wait cycle or response-wait cycle adds one stall cycle.
- `dmem_rvalid_i` is never asserted in the same cycle as the grant. An `rvalid` with no outstanding request is ignored.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum.
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - mcause constants: LOAD_MISALIGNED=4, LOAD_FAULT=5, STORE_MISALIGNED=6, STORE_FAULT=7.
- Sub-module `load_align`: purely combinational byte/half extraction and extension from (rdata, addr[1:0], funct3). It is reused by a future cache path.

## Test plan
- LB at 0x1003, rdata 0x80FF_1234, grant at cycle 0, rvalid at cycle 1 → stall in cycles 0–1; in DONE, `mem_data_o`=0xFFFF_FF80, `exception_o`=0.
- SH of 0x0000_ABCD at 0x2002 → `dmem_addr_o`=0x2000, wstrb=4'b1100, wdata=0xABCD_ABCD, we=1; DONE with data 0.
- LW at 0x3000 with grant held low for 3 cycles → request and address stable throughout; 3 extra stall cycles; LHU of rdata 0xFFFF0000 at 0x3002 → 0x0000_FFFF.
- LW at 0x4001 → no `dmem_req_o`, `stall_o`=0, `exception_o`=6'b100100 in the same cycle.
- SW with rvalid+err → in DONE, `exception_o`=6'b100111 and `mem_data_o`=0; flush in WAIT_RSP → DONE outputs all 0, and the next op issues normally.
- `rst_n`=0 for one cycle in WAIT_RSP, then a stale rvalid → state IDLE, outputs 0, stale response ignored.
